// File: rtl/toycpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toycpu_pkg
// Description : Shared widths, host-port FSM encoding and small helpers for
//               the toycpu register file and its host access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package toycpu_pkg;

    localparam int REG_W        = 16;
    localparam int REG_SEL_W    = 2;
    localparam int STARVE_CNT_W = 8;

    typedef enum logic [1:0] {
        HP_IDLE = 2'd0,
        HP_WR   = 2'd1,
        HP_RD   = 2'd2,
        HP_RSP  = 2'd3
    } host_port_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
        return (v == {STARVE_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage : toycpu_pkg
`default_nettype wire

// File: rtl/starve_timer.sv
`default_nettype none
// ============================================================================
// Module      : starve_timer
// Description : Saturating wait counter. Cleared by clr, advanced by en;
//               expired is high once the count has reached MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module starve_timer
    import toycpu_pkg::*;
#(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [STARVE_CNT_W-1:0] C_MAX = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] r_count;

    // Wait counter: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= sat_inc(r_count);
        end
    end

    assign expired = (r_count >= C_MAX);

endmodule : starve_timer
`default_nettype wire

// File: rtl/regfile_host_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_host_port
// Description : Debug-host access controller for the toycpu 4x16 register
//               file. Muxes host read/write commands onto the register file
//               write port and read port 2; the CPU keeps priority and the
//               host steals cycles through cpu_stall.
//               Optional feature macro: REGFILE_HOST_STARVE_GUARD_EN
//               (forces a stalled host write after STARVE_MAX wait cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_host_port
    import toycpu_pkg::*;
#(
    parameter int STARVE_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // host command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [REG_SEL_W-1:0] cmd_reg,
    input  logic [REG_W-1:0]     cmd_data,
    // host response channel
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REG_W-1:0]     rsp_data,
    // CPU side
    output logic                 cpu_stall,
    input  logic                 cpu_we,
    input  logic [REG_SEL_W-1:0] cpu_inReg,
    input  logic [REG_W-1:0]     cpu_dataIn,
    input  logic [REG_SEL_W-1:0] cpu_outReg2,
    output logic [REG_W-1:0]     cpu_dataOut2,
    // register file side
    output logic                 rf_we,
    output logic [REG_SEL_W-1:0] rf_inReg,
    output logic [REG_W-1:0]     rf_dataIn,
    output logic [REG_SEL_W-1:0] rf_outReg2,
    input  logic [REG_W-1:0]     rf_dataOut2
);

    localparam logic [1:0] ST_IDLE = HP_IDLE;
    localparam logic [1:0] ST_WR   = HP_WR;
    localparam logic [1:0] ST_RD   = HP_RD;
    localparam logic [1:0] ST_RSP  = HP_RSP;

    // Out-of-range wait limits are rejected at elaboration time.
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_starve_max_range_err
        $error("regfile_host_port: STARVE_MAX must be in 1..255");
    end

    logic [1:0]           r_state;
    logic                 r_cmd_write;
    logic [REG_SEL_W-1:0] r_cmd_reg;
    logic [REG_W-1:0]     r_cmd_data;
    logic [REG_W-1:0]     r_rsp_data;

    logic w_accept;
    logic w_in_wr;
    logic w_in_rd;
    logic w_force;
    logic w_host_wr;

    assign w_in_wr  = (r_state == ST_WR);
    assign w_in_rd  = (r_state == ST_RD);
    assign w_accept = cmd_valid & (r_state == ST_IDLE);

`ifdef REGFILE_HOST_STARVE_GUARD_EN
    logic w_expired;

    starve_timer #(
        .MAX (STARVE_MAX)
    ) u_starve_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_accept & cmd_write),
        .en      (w_in_wr & ~w_host_wr),
        .expired (w_expired)
    );

    // Once the wait limit is hit the host write is forced through a stall.
    assign w_force = w_in_wr & w_expired;
`else
    assign w_force = 1'b0;
`endif

    // The host owns the write port when the CPU is idle or the write is forced.
    assign w_host_wr = w_in_wr & (~cpu_we | w_force);

    // Command/response FSM with latched command fields and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_write <= 1'b0;
            r_cmd_reg   <= '0;
            r_cmd_data  <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_write <= cmd_write;
                        r_cmd_reg   <= cmd_reg;
                        r_cmd_data  <= cmd_data;
                        r_state     <= cmd_write ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if (w_host_wr) begin
                        r_rsp_data <= r_cmd_data;
                        r_state    <= ST_RSP;
                    end
                end
                ST_RD: begin
                    r_rsp_data <= rf_dataOut2;
                    r_state    <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Host-facing handshake outputs decode directly from the state.
    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RSP);
    assign rsp_data  = r_rsp_data;

    // The CPU is held during a host read and during a forced host write.
    assign cpu_stall = w_in_rd | w_force;

    // Register file port muxing: CPU pass-through unless the host owns a port.
    assign rf_we        = w_host_wr | (cpu_we & ~cpu_stall);
    assign rf_inReg     = w_host_wr ? r_cmd_reg  : cpu_inReg;
    assign rf_dataIn    = w_host_wr ? r_cmd_data : cpu_dataIn;
    assign rf_outReg2   = w_in_rd   ? r_cmd_reg  : cpu_outReg2;
    assign cpu_dataOut2 = rf_dataOut2;

    // r_cmd_write is kept for debug visibility of the accepted command type.
    logic w_unused;
    assign w_unused = r_cmd_write;

endmodule : regfile_host_port
`default_nettype wire

// File: tb/tb_regfile_host_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_host_port
// Description : Self-checking bench for regfile_host_port with a register
//               file harness, a transaction-level reference model and
//               directed vectors from the block's test plan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_host_port;

    localparam int C_STARVE = 3;
`ifdef REGFILE_HOST_STARVE_GUARD_EN
    localparam bit C_GUARD = 1'b1;
`else
    localparam bit C_GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_reg;
    logic [15:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        cpu_stall, cpu_we;
    logic [1:0]  cpu_inReg, cpu_outReg2;
    logic [15:0] cpu_dataIn, cpu_dataOut2;
    logic        rf_we;
    logic [1:0]  rf_inReg, rf_outReg2;
    logic [15:0] rf_dataIn, rf_dataOut2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_host_port #(.STARVE_MAX(C_STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cpu_stall(cpu_stall), .cpu_we(cpu_we), .cpu_inReg(cpu_inReg),
        .cpu_dataIn(cpu_dataIn), .cpu_outReg2(cpu_outReg2), .cpu_dataOut2(cpu_dataOut2),
        .rf_we(rf_we), .rf_inReg(rf_inReg), .rf_dataIn(rf_dataIn),
        .rf_outReg2(rf_outReg2), .rf_dataOut2(rf_dataOut2)
    );

    // Register file harness (no reset, combinational read port 2).
    logic [15:0] rf [4] = '{default: 16'h0000};
    always @(posedge clk) if (rf_we) rf[rf_inReg] <= rf_dataIn;
    assign rf_dataOut2 = rf[rf_outReg2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        m_has_cmd, m_write, m_has_rsp;
    logic [1:0]  m_reg;
    logic [15:0] m_data, m_rsp;
    int          m_wait;
    logic [15:0] m_regs [4] = '{default: 16'h0000};

    logic        e_forced, e_host_wr, e_stall, e_rf_we, e_cmd_ready;
    logic [1:0]  e_inReg, e_outReg2;
    logic [15:0] e_dataIn;

    always_comb begin
        e_forced    = C_GUARD && m_has_cmd && m_write && (m_wait >= C_STARVE);
        e_host_wr   = m_has_cmd && m_write && (!cpu_we || e_forced);
        e_stall     = m_has_cmd && (!m_write || e_forced);
        e_rf_we     = e_host_wr || (cpu_we && !e_stall);
        e_inReg     = e_host_wr ? m_reg  : cpu_inReg;
        e_dataIn    = e_host_wr ? m_data : cpu_dataIn;
        e_outReg2   = (m_has_cmd && !m_write) ? m_reg : cpu_outReg2;
        e_cmd_ready = !m_has_cmd && !m_has_rsp;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has_cmd <= 1'b0; m_write <= 1'b0; m_has_rsp <= 1'b0;
            m_reg <= 2'd0; m_data <= 16'h0; m_rsp <= 16'h0; m_wait <= 0;
        end else begin
            if (e_rf_we) m_regs[e_inReg] <= e_dataIn;
            if (m_has_rsp) begin
                if (rsp_ready) m_has_rsp <= 1'b0;
            end else if (m_has_cmd) begin
                if (!m_write) begin
                    m_rsp <= m_regs[m_reg]; m_has_rsp <= 1'b1; m_has_cmd <= 1'b0;
                end else if (e_host_wr) begin
                    m_rsp <= m_data; m_has_rsp <= 1'b1; m_has_cmd <= 1'b0;
                end else if (m_wait < 255) begin
                    m_wait <= m_wait + 1;
                end
            end else if (cmd_valid) begin
                m_has_cmd <= 1'b1; m_write <= cmd_write; m_reg <= cmd_reg;
                m_data <= cmd_data; m_wait <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(m_has_rsp));
        check("rsp_data", 32'(rsp_data), 32'(m_rsp));
        check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
        check("rf_we", 32'(rf_we), 32'(e_rf_we));
        check("rf_inReg", 32'(rf_inReg), 32'(e_inReg));
        check("rf_dataIn", 32'(rf_dataIn), 32'(e_dataIn));
        check("rf_outReg2", 32'(rf_outReg2), 32'(e_outReg2));
        check("cpu_dataOut2", 32'(cpu_dataOut2), 32'(rf_dataOut2));
        for (int i = 0; i < 4; i++) check($sformatf("reg%0d", i), 32'(rf[i]), 32'(m_regs[i]));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic we, input logic [1:0] r, input logic [15:0] d);
        cpu_we = we; cpu_inReg = r; cpu_dataIn = d;
    endtask

    task automatic host_cmd(input logic v, input logic w, input logic [1:0] r, input logic [15:0] d);
        cmd_valid = v; cmd_write = w; cmd_reg = r; cmd_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1; cpu_outReg2 = 2'd0;
        host_cmd(0, 0, 0, 16'h0); cpu_wr(0, 0, 16'h0);
        tick; tick;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        tick;

        // Preload r2 through the CPU pass-through path.
        cpu_wr(1, 2, 16'h1234); tick;
        cpu_wr(0, 0, 16'h0);

        // Host read of r2.
        host_cmd(1, 0, 2, 16'h0);
        tick;
        host_cmd(0, 0, 0, 16'h0);
        @(negedge clk);
        check("rd_stall", 32'(cpu_stall), 32'd1);
        check("rd_outReg2", 32'(rf_outReg2), 32'd2);
        check("rd_rsp_early", 32'(rsp_valid), 32'd0);
        tick;
        @(negedge clk);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(rsp_data), 32'h1234);
        check("rd_stall_once", 32'(cpu_stall), 32'd0);
        tick;

        // Uncontended host write r1 = BEEF.
        host_cmd(1, 1, 1, 16'hBEEF);
        tick;
        host_cmd(0, 0, 0, 16'h0);
        @(negedge clk);
        check("wr_rf_we", 32'(rf_we), 32'd1);
        check("wr_inReg", 32'(rf_inReg), 32'd1);
        check("wr_dataIn", 32'(rf_dataIn), 32'hBEEF);
        tick;
        @(negedge clk);
        check("wr_rsp_data", 32'(rsp_data), 32'hBEEF);
        check("wr_r1", 32'(rf[1]), 32'hBEEF);
        tick;

        // Collision: host writes r3 while the CPU writes r3 for 4 cycles.
        host_cmd(1, 1, 3, 16'h0A0A);
        tick;
        host_cmd(0, 0, 0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            cpu_wr(1, 3, 16'h5555);
            @(negedge clk);
`ifndef REGFILE_HOST_STARVE_GUARD_EN
            check("col_cpu_data", 32'(rf_dataIn), 32'h5555);
            check("col_no_rsp", 32'(rsp_valid), 32'd0);
`endif
            tick;
        end
        cpu_wr(0, 0, 16'h0);
        @(negedge clk);
`ifndef REGFILE_HOST_STARVE_GUARD_EN
        check("col_host_data", 32'(rf_dataIn), 32'h0A0A);
        check("col_host_reg", 32'(rf_inReg), 32'd3);
`endif
        tick; tick;
        @(negedge clk);
        check("col_final_r3", 32'(rf[3]), 32'h0A0A);
        tick;

        // Starvation: CPU holds cpu_we high writing r0 while host writes r1.
        host_cmd(1, 1, 1, 16'h7777);
        tick;
        host_cmd(0, 0, 0, 16'h0);
        for (int k = 1; k <= 6; k++) begin
            cpu_wr(1, 0, 16'h1111);
            @(negedge clk);
            check($sformatf("starve_stall_c%0d", k), 32'(cpu_stall),
                  32'((C_GUARD && k == C_STARVE + 1) ? 1 : 0));
            check($sformatf("starve_rsp_c%0d", k), 32'(rsp_valid),
                  32'((C_GUARD && k == C_STARVE + 2) ? 1 : 0));
            tick;
        end
        cpu_wr(0, 0, 16'h0);
        tick; tick;
        @(negedge clk);
        check("starve_r1", 32'(rf[1]), 32'h7777);
        check("starve_idle", 32'(cmd_ready), 32'd1);
        tick;

        // Response back-pressure: read r1 with rsp_ready low for 5 cycles.
        rsp_ready = 1'b0;
        host_cmd(1, 0, 1, 16'h0);
        tick;
        host_cmd(0, 0, 0, 16'h0);
        tick;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'h7777);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        @(negedge clk);
        check("bp_release", 32'(cmd_ready), 32'd1);
        tick;

        // Reset while a host write to r2 waits behind the CPU.
        host_cmd(1, 1, 2, 16'hDEAD);
        tick;
        host_cmd(0, 0, 0, 16'h0);
        cpu_wr(1, 0, 16'h3333);
        @(negedge clk);
        check("rstwr_cpu_reg", 32'(rf_inReg), 32'd0);
        tick;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstwr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstwr_rsp_data", 32'(rsp_data), 32'h0);
        check("rstwr_stall", 32'(cpu_stall), 32'd0);
        cpu_wr(0, 0, 16'h0);
        tick; tick;
        rst_n = 1'b1;
        tick; tick;
        @(negedge clk);
        check("rstwr_r2_kept", 32'(rf[2]), 32'h1234);
        check("rstwr_ready", 32'(cmd_ready), 32'd1);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_host_port
`default_nettype wire

// File: doc/regfile_host_port.md
# regfile_host_port

Host-side access controller for the toycpu 4×16-bit register file. It accepts single read/write commands from a debug host over a valid/ready handshake and drives the register file's write port and second read port. It shares those ports with the CPU datapath: the CPU has priority, and the host steals cycles through `cpu_stall`. It sits between the CPU core, the register file and the debug/host bus.

## Interface
- `STARVE_MAX`, default 15: cycles a pending host write waits behind `cpu_we` before forcing a stall (guard build only); legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  controller accepts a command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_reg`  in  2  target register number.
- `cmd_data`  in  16  write data (ignored for reads).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  host consumes response.
- `rsp_data`  out  16  read data; for writes, echo of written data.
- `cpu_stall`  out  1  CPU must hold its state; its `cpu_we` is ignored this cycle.
- `cpu_we`, `cpu_inReg[1:0]`, `cpu_dataIn[15:0]`  in  CPU write-port request.
- `cpu_outReg2`  in  2  CPU read-port-2 select.
- `cpu_dataOut2`  out  16  read data returned to CPU (= `rf_dataOut2`).
- `rf_we`, `rf_inReg[1:0]`, `rf_dataIn[15:0]`  out  register file write port.
- `rf_outReg2`  out  2  register file read-port-2 select.
- `rf_dataOut2`  in  16  register file read data, combinational.
- Read port 1 is not routed through this block.

## Operation
- FSM states: IDLE, WR, RD, RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch `cmd_write`, `cmd_reg`, `cmd_data`.
  - Go to WR if `cmd_write`=1, otherwise to RD.
- WR, `cpu_we`=0 (or stall forced):
  - `rf_we`=1, `rf_inReg`=latched reg, `rf_dataIn`=latched data.
  - Load `rsp_data` with the latched data; go to RSP.
- WR, `cpu_we`=1 and no forced stall:
  - CPU write passes through; the host write is held.
  - Wait counter increments, saturating.
- RD:
  - `cpu_stall`=1, `rf_outReg2`=latched reg.
  - Capture `rf_dataOut2` into `rsp_data` at the clock edge; go to RSP.
- RSP:
  - `rsp_valid`=1, `rsp_data` stable until `rsp_ready`; then go to IDLE.
  - `cmd_ready`=0 in every state except IDLE.
- Whenever the host does not own a port, the `rf_*` signals equal the corresponding `cpu_*` inputs combinationally.
- Same-register collision: CPU and host writes to one register in one cycle. The CPU write lands first and the host write lands on a later cycle, so the host value persists.
- Wait counter clears on entry to WR.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0, `cpu_stall`=0, wait counter=0.
- Reset mid-operation: the pending command and response are dropped with no partial write. An `rf_we` already committed on an earlier edge stands.
- Read latency: accept at edge N, RD during cycle N+1, `rsp_valid` from cycle N+2.
- Uncontended write: `rf_we` in cycle N+1, register updated at the end of N+1, `rsp_valid` from N+2.
- Contended write: response delayed one cycle per `cpu_we` cycle; bounded by `STARVE_MAX`+1 in the guard build.
- `cpu_stall` is asserted for exactly one cycle per host read, and for one cycle per forced write.
- Back-to-back commands: a minimum of 3 cycles per command when `rsp_ready` is held high.

## Configuration
- `REGFILE_HOST_STARVE_GUARD_EN` defined:
  - When the wait counter reaches `STARVE_MAX` in WR, the next cycle asserts `cpu_stall`=1.
  - In that cycle the host write is performed regardless of `cpu_we`.
- Not defined:
  - No counter is built.
  - A host write waits indefinitely while `cpu_we`=1.
  - `cpu_stall` is asserted only in RD.

## Structure
- Shared package `toycpu_pkg`:
  - `REG_W`=16, `REG_SEL_W`=2.
  - FSM state enum `host_port_state_t`.
- Sub-module `starve_timer`: saturating wait counter with clear/enable and a `expired` flag. Instantiated only under the macro.

## Test plan
- Reset, then host read of r2 preloaded 0x1234 → `cpu_stall` high for 1 cycle, `rsp_valid` 2 cycles after accept, `rsp_data`=0x1234.
- Host write r1=0xBEEF with `cpu_we`=0 → `rf_we` 1 cycle after accept, r1=0xBEEF, `rsp_data`=0xBEEF.
- Host write r3=0x0A0A while the CPU writes r3=0x5555 for 4 consecutive cycles → CPU writes pass, host write lands in cycle 5, final r3=0x0A0A.
- Guard build, `STARVE_MAX`=3, `cpu_we` held high → `cpu_stall` asserted after the 3rd wait cycle, host write performed. No-guard build: response withheld until `cpu_we` drops.
- `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0 throughout.
- `rst_n` asserted while in WR → outputs return to reset values immediately, no host write occurs, `cmd_ready`=1 after release.
